byte_pack32: RTL

Byte-to-word packer: the receive-side counterpart of the 32-bit byte-lane memory, which splits a word into four bytes. It accepts a stream of 8-bit bytes on a valid/ready handshake and assembles each group of four into a 32-bit word. Byte 0 lands in the same lane the memory reads out at address 0. The word is presented on a registered valid/ready output with full backpressure. It sits between a byte-serial source (memory read port, UART, SPI) and 32-bit word consumers.

---
 rtl/pack32_pkg.sv | 26 ++
 rtl/byte_pack32.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pack32_pkg.sv
// Shared types and helpers for the byte-to-word packer.
// Lane mapping follows the byte-lane memory's address-0 lane.
package pack32_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } fill_e;

  // Byte lane written in a given fill state.
  function automatic logic [1:0] lane(
    input fill_e st,
    input bit    msb_first
  );
    logic [1:0] s;
    s = st;
    return msb_first ? (2'd3 - s) : s;
  endfunction

endpackage

// File: rtl/byte_pack32.sv
// Packs a valid/ready byte stream into registered 32-bit words.
// Define PACK32_FLUSH_EN to add flush/out_bytes for partial words.
module byte_pack32
  import pack32_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic [15:0]       word_cnt
`ifdef PACK32_FLUSH_EN
  ,
  input  logic              flush,
  output logic [2:0]        out_bytes
`endif
);

  fill_e             state_q, state_d;
  fill_e             nxt_state;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] acc_w, nxt_acc;
  logic [WORD_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [4:0]        sh;
  logic              byte_fire;
  logic              word_fire;
  logic              out_free;
  logic              last_byte;
  logic              pend;

`ifdef PACK32_FLUSH_EN
  logic       pend_q, pend_d;
  logic       flush_now;
  logic [2:0] bytes_q, bytes_d;
  assign pend = pend_q;
`else
  assign pend = 1'b0;
`endif

  assign sh    = {lane(state_q, MSB_FIRST), 3'b000};
  assign acc_w = acc_q | (WORD_W'(in_data) << sh);

  always_comb begin
    out_free  = !out_valid_q || out_ready;
    last_byte = (state_q == S3);
    in_ready  = !rst && !pend
             && (!last_byte || out_free);
    byte_fire = in_valid && in_ready;
    word_fire = out_valid_q && out_ready;

    nxt_state = byte_fire
              ? fill_e'(2'(state_q) + 2'd1)
              : state_q;
    nxt_acc   = byte_fire ? acc_w : acc_q;

    state_d     = nxt_state;
    acc_d       = nxt_acc;
    out_d       = out_q;
    out_valid_d = out_valid_q && !out_ready;
    cnt_d       = cnt_q + 16'(word_fire);
`ifdef PACK32_FLUSH_EN
    bytes_d     = bytes_q;
    pend_d      = pend_q;
`endif

    if (byte_fire && last_byte) begin
      out_d       = acc_w;
      out_valid_d = 1'b1;
      acc_d       = '0;
`ifdef PACK32_FLUSH_EN
      bytes_d     = 3'd4;
`endif
    end

`ifdef PACK32_FLUSH_EN
    // A byte at the same edge counts toward the partial word.
    flush_now = pend_q
             || (flush && nxt_state != S0);
    if (flush_now) begin
      if (out_free) begin
        out_d       = nxt_acc;
        out_valid_d = 1'b1;
        bytes_d     = {1'b0, 2'(nxt_state)};
        state_d     = S0;
        acc_d       = '0;
        pend_d      = 1'b0;
      end else begin
        pend_d      = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
`ifdef PACK32_FLUSH_EN
      pend_q      <= 1'b0;
      bytes_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
`ifdef PACK32_FLUSH_EN
      pend_q      <= pend_d;
      bytes_q     <= bytes_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign word_cnt  = cnt_q;
`ifdef PACK32_FLUSH_EN
  assign out_bytes = bytes_q;
`endif

endmodule
